// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 write sequencer.
// States, wait classes, init ROM entry layout and LCD command bytes.
package lcd_pkg;

    typedef enum logic [2:0] {
        S_POWERUP,
        S_LOAD,
        S_SETUP,
        S_EN_HI,
        S_HOLD,
        S_WAIT,
        S_IDLE
    } state_t;

    typedef enum logic [1:0] {
        WAIT_CMD,
        WAIT_CLEAR,
        WAIT_INIT
    } wait_sel_t;

    typedef struct packed {
        logic      rs;
        logic [7:0] data;
        wait_sel_t wait_sel;
    } init_entry_t;

    localparam int INIT_LEN   = 8;
    localparam int INIT_IDX_W = $clog2(INIT_LEN);

    localparam logic [7:0] LCD_WAKE       = 8'h30;
    localparam logic [7:0] LCD_FUNC_8B_2L = 8'h38;
    localparam logic [7:0] LCD_DISP_OFF   = 8'h08;
    localparam logic [7:0] LCD_CLEAR      = 8'h01;
    localparam logic [7:0] LCD_ENTRY_INC  = 8'h06;
    localparam logic [7:0] LCD_DISP_ON    = 8'h0C;

    // Clear (0x01) and return-home (0x02/0x03) are the slow commands.
    function automatic wait_sel_t user_wait_sel(input logic rs, input logic [7:0] data);
        if (!rs && (data == 8'h01 || data == 8'h02 || data == 8'h03)) begin
            return WAIT_CLEAR;
        end
        return WAIT_CMD;
    endfunction

endpackage

// File: rtl/lcd_init_rom.sv
// Fixed power-up command list for an 8-bit, 2-line, 5x8 panel.
// Purely combinational index -> entry lookup.
module lcd_init_rom
    import lcd_pkg::*;
(
    input  logic [INIT_IDX_W-1:0] idx_i,
    output init_entry_t           entry_o
);

    always_comb begin
        entry_o = '{rs: 1'b0, data: LCD_DISP_ON, wait_sel: WAIT_CMD};
        case (idx_i)
            3'd0: entry_o = '{rs: 1'b0, data: LCD_WAKE,       wait_sel: WAIT_INIT};
            3'd1: entry_o = '{rs: 1'b0, data: LCD_WAKE,       wait_sel: WAIT_CMD};
            3'd2: entry_o = '{rs: 1'b0, data: LCD_WAKE,       wait_sel: WAIT_CMD};
            3'd3: entry_o = '{rs: 1'b0, data: LCD_FUNC_8B_2L, wait_sel: WAIT_CMD};
            3'd4: entry_o = '{rs: 1'b0, data: LCD_DISP_OFF,   wait_sel: WAIT_CMD};
            3'd5: entry_o = '{rs: 1'b0, data: LCD_CLEAR,      wait_sel: WAIT_CLEAR};
            3'd6: entry_o = '{rs: 1'b0, data: LCD_ENTRY_INC,  wait_sel: WAIT_CMD};
            3'd7: entry_o = '{rs: 1'b0, data: LCD_DISP_ON,    wait_sel: WAIT_CMD};
            default: ;
        endcase
    end

endmodule

// File: rtl/lcd_hd44780_ctrl.sv
// HD44780 write sequencer: power-up wait, init ROM playback, then single
// valid/ready writes, each a timed EN pulse followed by an execution wait.
module lcd_hd44780_ctrl #(
    parameter int unsigned POWERUP_CYC    = 750000,
    parameter int unsigned SETUP_CYC      = 4,
    parameter int unsigned EN_HIGH_CYC    = 25,
    parameter int unsigned HOLD_CYC       = 4,
    parameter int unsigned CMD_WAIT_CYC   = 2500,
    parameter int unsigned CLEAR_WAIT_CYC = 100000,
    parameter int unsigned INIT_WAIT_CYC  = 250000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic       req_rs,
    input  logic [7:0] req_data,
    output logic       req_ready,
    output logic       init_done,
    output logic       busy,
    output logic       data_out_en,
    output logic       data_out_on,
    output logic       data_out_rs,
    output logic       data_out_rw,
    output logic [7:0] data_out
);
    import lcd_pkg::*;

    function automatic int unsigned umax(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned MAX_CYC = umax(umax(umax(POWERUP_CYC, SETUP_CYC),
                                                umax(EN_HIGH_CYC, HOLD_CYC)),
                                           umax(umax(CMD_WAIT_CYC, CLEAR_WAIT_CYC),
                                                INIT_WAIT_CYC));
    localparam int CNT_W = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t PU_LAST    = cnt_t'(POWERUP_CYC - 1);
    localparam cnt_t SETUP_LAST = cnt_t'(SETUP_CYC - 1);
    localparam cnt_t EN_LAST    = cnt_t'(EN_HIGH_CYC - 1);
    localparam cnt_t HOLD_LAST  = cnt_t'(HOLD_CYC - 1);
    localparam cnt_t CMD_LAST   = cnt_t'(CMD_WAIT_CYC - 1);
    localparam cnt_t CLEAR_LAST = cnt_t'(CLEAR_WAIT_CYC - 1);
    localparam cnt_t INIT_LAST  = cnt_t'(INIT_WAIT_CYC - 1);
    localparam logic [INIT_IDX_W-1:0] IDX_LAST = INIT_IDX_W'(INIT_LEN - 1);

    state_t                  state_q, state_d;
    cnt_t                    cnt_q, cnt_d;
    logic [INIT_IDX_W-1:0]   idx_q, idx_d;
    logic                    rs_q, rs_d;
    logic [7:0]              data_q, data_d;
    wait_sel_t               wsel_q, wsel_d;
    logic                    init_done_q, init_done_d;
    logic                    en_q, on_q, ready_q, busy_q;
    cnt_t                    wait_last;
    logic [INIT_IDX_W-1:0]   load_idx;
    init_entry_t             rom_entry;

    // LOAD is only ever reached from POWERUP (entry 0) or from an init WAIT.
    assign load_idx = (state_q == S_WAIT) ? idx_q + 1'b1 : '0;

    lcd_init_rom u_rom (
        .idx_i   (load_idx),
        .entry_o (rom_entry)
    );

    always_comb begin
        wait_last = CMD_LAST;
        case (wsel_q)
            WAIT_CLEAR: wait_last = CLEAR_LAST;
            WAIT_INIT:  wait_last = INIT_LAST;
            default:    wait_last = CMD_LAST;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 1'b1;
        idx_d       = idx_q;
        rs_d        = rs_q;
        data_d      = data_q;
        wsel_d      = wsel_q;
        init_done_d = init_done_q;

        case (state_q)
            S_POWERUP: begin
                // Count only from the cycle power is switched on.
                if (!on_q) begin
                    cnt_d = cnt_q;
                end else if (cnt_q == PU_LAST) begin
                    state_d = S_LOAD;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            end
            S_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    state_d = S_EN_HI;
                    cnt_d   = '0;
                end
            end
            S_EN_HI: begin
                if (cnt_q == EN_LAST) begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
                end
            end
            S_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end
            end
            S_WAIT: begin
                if (cnt_q == wait_last) begin
                    cnt_d = '0;
                    if (init_done_q) begin
                        state_d = S_IDLE;
                    end else if (idx_q == IDX_LAST) begin
                        init_done_d = 1'b1;
                        state_d     = S_IDLE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_LOAD;
                    end
                end
            end
            S_IDLE: begin
                cnt_d = '0;
                if (req_valid) begin
                    rs_d    = req_rs;
                    data_d  = req_data;
                    wsel_d  = user_wait_sel(req_rs, req_data);
                    state_d = S_SETUP;
                end
            end
            default: begin
                state_d = S_POWERUP;
                cnt_d   = '0;
            end
        endcase

        if (state_d == S_LOAD) begin
            rs_d    = rom_entry.rs;
            data_d  = rom_entry.data;
            wsel_d  = rom_entry.wait_sel;
            state_d = S_SETUP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_POWERUP;
            cnt_q       <= '0;
            idx_q       <= '0;
            rs_q        <= 1'b0;
            data_q      <= 8'h00;
            wsel_q      <= WAIT_CMD;
            init_done_q <= 1'b0;
            en_q        <= 1'b0;
            on_q        <= 1'b0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            rs_q        <= rs_d;
            data_q      <= data_d;
            wsel_q      <= wsel_d;
            init_done_q <= init_done_d;
            en_q        <= (state_d == S_EN_HI);
            on_q        <= 1'b1;
            ready_q     <= (state_d == S_IDLE);
            busy_q      <= (state_d != S_IDLE);
        end
    end

    assign req_ready   = ready_q;
    assign init_done   = init_done_q;
    assign busy        = busy_q;
    assign data_out_en = en_q;
    assign data_out_on = on_q;
    assign data_out_rs = rs_q;
    assign data_out_rw = 1'b0;
    assign data_out    = data_q;

endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// Directed bench for lcd_hd44780_ctrl with shortened timing parameters.
module tb_lcd_hd44780_ctrl;

    localparam int PU = 20, ST = 2, EH = 3, HO = 2, CW = 10, CLW = 40, IW = 30;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_rs = 1'b0;
    logic [7:0] req_data = 8'h00;
    logic       req_ready, init_done, busy;
    logic       data_out_en, data_out_on, data_out_rs, data_out_rw;
    logic [7:0] data_out;

    lcd_hd44780_ctrl #(
        .POWERUP_CYC(PU), .SETUP_CYC(ST), .EN_HIGH_CYC(EH), .HOLD_CYC(HO),
        .CMD_WAIT_CYC(CW), .CLEAR_WAIT_CYC(CLW), .INIT_WAIT_CYC(IW)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_rs(req_rs),
        .req_data(req_data), .req_ready(req_ready), .init_done(init_done),
        .busy(busy), .data_out_en(data_out_en), .data_out_on(data_out_on),
        .data_out_rs(data_out_rs), .data_out_rw(data_out_rw), .data_out(data_out)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // EN pulse log, filled while ticking
    int         p_n = 0;
    int         p_rise [16];
    int         p_w    [16];
    logic [7:0] p_dat  [16];
    logic       p_rs   [16];
    int         unstable = 0;
    int         rw_bad   = 0;
    logic       prev_en  = 1'b0;

    typedef struct {
        logic [7:0] data;
        int         wait_c;
    } init_vec_t;
    init_vec_t init_tbl [8];

    typedef struct {
        int         cyc;
        logic       exp_en;
        logic       exp_ready;
        logic       exp_rs;
        logic [7:0] exp_dat;
        logic       drv;
        logic       nv;
        logic       nrs;
        logic [7:0] ndat;
    } wr_vec_t;
    wr_vec_t wr_tbl [19];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (data_out_en && !prev_en && p_n < 16) begin
            p_rise[p_n] = cyc;
            p_dat[p_n]  = data_out;
            p_rs[p_n]   = data_out_rs;
            p_w[p_n]    = 0;
            p_n++;
        end
        if (data_out_en && p_n > 0) begin
            p_w[p_n-1]++;
            if (data_out != p_dat[p_n-1] || data_out_rs != p_rs[p_n-1]) unstable++;
        end
        if (data_out_rw) rw_bad++;
        prev_en = data_out_en;
    endtask

    task automatic run_to(input int t);
        while (cyc < t) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_en", data_out_en, 0);
        chk("rst_on", data_out_on, 0);
        chk("rst_rs", data_out_rs, 0);
        chk("rst_data", data_out, 8'h00);
        chk("rst_ready", req_ready, 0);
        chk("rst_init_done", init_done, 0);
        chk("rst_busy", busy, 1);
        rst = 1'b0;
        tick();
        cyc = 0;
        p_n = 0;
        chk("on_first_edge", data_out_on, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_rise;
        int base_n;

        init_tbl[0] = '{8'h30, IW};
        init_tbl[1] = '{8'h30, CW};
        init_tbl[2] = '{8'h30, CW};
        init_tbl[3] = '{8'h38, CW};
        init_tbl[4] = '{8'h08, CW};
        init_tbl[5] = '{8'h01, CLW};
        init_tbl[6] = '{8'h06, CW};
        init_tbl[7] = '{8'h0C, CW};

        //            cyc en rdy rs data  drv v  rs  data
        wr_tbl[0]  = '{206, 0, 1, 0, 8'h0C, 1, 1, 1, 8'h41};
        wr_tbl[1]  = '{207, 0, 0, 1, 8'h41, 1, 0, 0, 8'h00};
        wr_tbl[2]  = '{208, 0, 0, 1, 8'h41, 0, 0, 0, 8'h00};
        wr_tbl[3]  = '{209, 1, 0, 1, 8'h41, 0, 0, 0, 8'h00};
        wr_tbl[4]  = '{211, 1, 0, 1, 8'h41, 0, 0, 0, 8'h00};
        wr_tbl[5]  = '{212, 0, 0, 1, 8'h41, 0, 0, 0, 8'h00};
        wr_tbl[6]  = '{213, 0, 0, 1, 8'h41, 0, 0, 0, 8'h00};
        wr_tbl[7]  = '{214, 0, 0, 1, 8'h41, 0, 0, 0, 8'h00};
        wr_tbl[8]  = '{223, 0, 0, 1, 8'h41, 0, 0, 0, 8'h00};
        wr_tbl[9]  = '{224, 0, 1, 1, 8'h41, 1, 1, 0, 8'h01};
        wr_tbl[10] = '{225, 0, 0, 0, 8'h01, 1, 1, 0, 8'h80};
        wr_tbl[11] = '{227, 1, 0, 0, 8'h01, 0, 0, 0, 8'h00};
        wr_tbl[12] = '{230, 0, 0, 0, 8'h01, 0, 0, 0, 8'h00};
        wr_tbl[13] = '{250, 0, 0, 0, 8'h01, 0, 0, 0, 8'h00};
        wr_tbl[14] = '{271, 0, 0, 0, 8'h01, 0, 0, 0, 8'h00};
        wr_tbl[15] = '{272, 0, 1, 0, 8'h01, 0, 0, 0, 8'h00};
        wr_tbl[16] = '{273, 0, 0, 0, 8'h80, 1, 0, 0, 8'h00};
        wr_tbl[17] = '{275, 1, 0, 0, 8'h80, 0, 0, 0, 8'h00};
        wr_tbl[18] = '{290, 0, 1, 0, 8'h80, 0, 0, 0, 8'h00};

        // Init sequence with no requests
        do_reset();
        run_to(205);
        chk("init_done_early", init_done, 0);
        chk("ready_early", req_ready, 0);
        chk("busy_during_init", busy, 1);
        run_to(206);
        chk("init_done_206", init_done, 1);
        chk("ready_206", req_ready, 1);
        chk("busy_idle", busy, 0);
        chk("init_pulse_count", p_n, 8);
        exp_rise = PU + ST;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("init%0d_rise", k), p_rise[k], exp_rise);
            chk($sformatf("init%0d_data", k), p_dat[k], init_tbl[k].data);
            chk($sformatf("init%0d_rs", k), p_rs[k], 0);
            chk($sformatf("init%0d_width", k), p_w[k], EH);
            exp_rise += ST + EH + HO + init_tbl[k].wait_c;
        end

        // User writes: data 0x41, then clear followed by held 0x80
        base_n = p_n;
        for (int i = 0; i < 19; i++) begin
            run_to(wr_tbl[i].cyc);
            chk($sformatf("wr%0d_en", i), data_out_en, wr_tbl[i].exp_en);
            chk($sformatf("wr%0d_ready", i), req_ready, wr_tbl[i].exp_ready);
            chk($sformatf("wr%0d_rs", i), data_out_rs, wr_tbl[i].exp_rs);
            chk($sformatf("wr%0d_data", i), data_out, wr_tbl[i].exp_dat);
            if (wr_tbl[i].drv) begin
                req_valid = wr_tbl[i].nv;
                req_rs    = wr_tbl[i].nrs;
                req_data  = wr_tbl[i].ndat;
            end
        end
        chk("user_pulse_count", p_n - base_n, 3);
        chk("user_widths", p_w[8] + p_w[9] + p_w[10], 3 * EH);
        chk("en_data_stable", unstable, 0);
        chk("rw_always_0", rw_bad, 0);

        // Request held during init is accepted only once IDLE
        do_reset();
        run_to(50);
        req_valid = 1'b1;
        req_rs    = 1'b0;
        req_data  = 8'h55;
        run_to(205);
        chk("held_ready_205", req_ready, 0);
        chk("held_no_extra_pulse", p_n, 8);
        run_to(206);
        chk("held_ready_206", req_ready, 1);
        chk("held_data_206", data_out, 8'h0C);
        run_to(207);
        chk("held_accept_ready", req_ready, 0);
        chk("held_accept_data", data_out, 8'h55);
        req_valid = 1'b0;
        run_to(209);
        chk("held_en_rise", data_out_en, 1);
        chk("held_pulse_count", p_n, 9);
        run_to(210);

        // Reset pulse while EN is high
        rst = 1'b1;
        tick();
        chk("midrst_en", data_out_en, 0);
        chk("midrst_data", data_out, 8'h00);
        chk("midrst_on", data_out_on, 0);
        chk("midrst_init_done", init_done, 0);
        chk("midrst_ready", req_ready, 0);
        chk("midrst_busy", busy, 1);
        rst = 1'b0;
        tick();
        cyc = 0;
        p_n = 0;
        chk("midrst_on_back", data_out_on, 1);
        run_to(205);
        chk("rerun_init_done_205", init_done, 0);
        run_to(206);
        chk("rerun_init_done_206", init_done, 1);
        chk("rerun_ready_206", req_ready, 1);
        chk("rerun_pulse_count", p_n, 8);
        chk("rerun_first_data", p_dat[0], 8'h30);
        chk("rerun_first_rise", p_rise[0], PU + ST);
        chk("rw_always_0_end", rw_bad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
